// File: rtl/riscv_pkg.sv
// Shared types and helpers for the fetch slice.
// Holds the fetch queue entry layout and pc alignment.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] pc
  );
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst} pairs between fetch and decode.
// Flush wins over push and pop; head is entry 0.
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0;
  fetch_entry_t e1;
  fetch_entry_t n_e0;
  fetch_entry_t n_e1;
  logic [1:0]   n_count;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = e0;

  // Next queue contents; entry 0 keeps its value when emptied.
  always_comb begin
    n_e0    = e0;
    n_e1    = e1;
    n_count = count;
    if (flush) begin
      n_count = 2'd0;
    end else if (push_ok && pop_ok) begin
      if (count == 2'd2) begin
        n_e0 = e1;
        n_e1 = push_entry;
      end else begin
        n_e0 = push_entry;
      end
    end else if (push_ok) begin
      if (count == 2'd0) begin
        n_e0 = push_entry;
      end else begin
        n_e1 = push_entry;
      end
      n_count = count + 2'd1;
    end else if (pop_ok) begin
      if (count == 2'd2) begin
        n_e0 = e1;
      end
      n_count = count - 2'd1;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      e0    <= n_e0;
      e1    <= n_e1;
      count <= n_count;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the pc, drives the ROM, queues results.
// Redirect flushes everything and restarts at the new pc.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter int          NADDR_BITS = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [NADDR_BITS-1:0] imem_address,
  input  logic [31:0]           imem_q,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc
);

  logic [31:0]  pc;
  logic         pending;
  logic [31:0]  pend_pc;
  logic [1:0]   q_count;
  fetch_entry_t head;
  fetch_entry_t cap;
  logic         push;
  logic         pop;
  logic         issue;
  logic [2:0]   occ;

  assign imem_address = pc[NADDR_BITS-1:0];
  assign inst_valid   = (q_count != 2'd0);
  assign inst         = head.inst;
  assign inst_pc      = head.pc;

  assign pop  = inst_valid && inst_ready && !redirect;
  assign push = pending && !redirect;
  assign cap  = '{pc: pend_pc, inst: imem_q};

  // Slots committed after this edge; the head leaving
  // this cycle frees a slot for full throughput.
  assign occ = {1'b0, q_count}
             + {2'b00, pending}
             - {2'b00, pop};

  assign issue = !redirect && (occ < 3'd2);

  // Pc and the single in-flight ROM request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= align4(RESET_PC);
      pending <= 1'b0;
      pend_pc <= '0;
    end else if (redirect) begin
      pc      <= align4(redirect_pc);
      pending <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pend_pc <= pc;
        pc      <= pc + 32'd4;
      end
    end
  end

  fetch_queue u_queue (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (push),
    .push_entry (cap),
    .pop        (pop),
    .head       (head),
    .count      (q_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch with a behavioural ROM and
// an in-order delivery scoreboard.
module tb_inst_fetch;

  logic        clock;
  logic        reset_n;
  logic [7:0]  imem_address;
  logic [31:0] imem_q;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] rom [64];

  int checks;
  int errors;

  // model state
  logic [31:0] exp_pc;
  int          quiet;
  bit          have_prev;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;

  inst_fetch #(
    .NADDR_BITS (8),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_address (imem_address),
    .imem_q       (imem_q),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM: one-cycle registered read, word indexed
  always @(posedge clock)
    imem_q <= rom[imem_address[7:2]];

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = 32'h1300_0000 + 32'(i);
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h0020_81B3;
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: after a flush, valid is low for two cycles
  // and then stays high; deliveries are consecutive pcs.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_pc    = 32'h0;
      quiet     = 2;
      have_prev = 0;
    end else begin
      chk("valid_timing", 32'(inst_valid),
          32'(quiet == 0));
      if (quiet > 0) quiet--;
      if (have_prev) begin
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_inst", inst, prev_inst);
      end
      have_prev = inst_valid && !inst_ready && !redirect;
      prev_pc   = inst_pc;
      prev_inst = inst;
      if (redirect) begin
        exp_pc = redirect_pc & ~32'd3;
        quiet  = 2;
      end else if (inst_valid && inst_ready) begin
        chk("sb_pc", inst_pc, exp_pc);
        chk("sb_inst", inst, rom[exp_pc[7:2]]);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    chk(nm, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] pa;
    bit wrap_seen;
    bit pc100_seen;
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_addr", 32'(imem_address), 32'd0);
    reset_n = 1'b1;

    // streaming from reset
    tick();
    chk("t1_addr1", 32'(imem_address), 32'h4);
    chk("t1_v1", 32'(inst_valid), 32'd0);
    tick();
    chk("t1_v2", 32'(inst_valid), 32'd1);
    chk("t1_pc0", inst_pc, 32'h0);
    chk("t1_i0", inst, 32'h0050_0093);
    tick();
    chk("t1_pc4", inst_pc, 32'h4);
    chk("t1_i4", inst, 32'h0010_0113);
    tick();
    chk("t1_pc8", inst_pc, 32'h8);
    chk("t1_i8", inst, 32'h0020_81B3);
    repeat (4) tick();

    // async reset pulse mid-stream, then backpressure
    inst_ready = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("rst_async_v", 32'(inst_valid), 32'd0);
    chk("rst_async_a", 32'(imem_address), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    chk("bp_first_v", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr", 32'(imem_address), 32'h8);
      chk("bp_pc", inst_pc, 32'h0);
      tick();
    end
    inst_ready = 1'b1;
    repeat (6) tick();

    // redirect with a full queue
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    chk("rd_v0", 32'(inst_valid), 32'd0);
    wait_valid("rd_wait");
    chk("rd_pc20", inst_pc, 32'h20);
    chk("rd_i20", inst, rom[8]);
    tick();
    chk("rd_pc24", inst_pc, 32'h24);
    repeat (3) tick();

    // back-to-back redirects
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("bb_v0", 32'(inst_valid), 32'd0);
    wait_valid("bb_wait");
    chk("bb_pc80", inst_pc, 32'h80);
    repeat (3) tick();

    // address wrap
    redirect    = 1'b1;
    redirect_pc = 32'hF0;
    tick();
    redirect   = 1'b0;
    wrap_seen  = 0;
    pc100_seen = 0;
    pa         = imem_address;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (pa == 8'hFC && imem_address == 8'h00)
        wrap_seen = 1;
      pa = imem_address;
      if (inst_valid && inst_pc == 32'h100) begin
        chk("wr_i100", inst, 32'h0050_0093);
        pc100_seen = 1;
      end
    end
    chk("wr_addr", 32'(wrap_seen), 32'd1);
    chk("wr_pc100", 32'(pc100_seen), 32'd1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
